// File: rtl/spm_host_loader.sv
`timescale 1ns/1ps
// Byte-stream host for the core: loads ISPM/DSPM words with the core held in reset, then runs it and watches tohost.
// Latency: the memory write strobe is the cycle after the 4th byte of a word; RUN status is updated on the terminating cycle.
// Backpressure: in_ready drops for the one-cycle WRITE and for the whole RUN; every other state takes one byte per cycle.
module spm_host_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_CYCLES = 10000,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_data,
    output logic                  core_reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_enable,
    output logic                  imem_write,
    output logic [31:0]           imem_data_in,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic                  dmem_enable,
    output logic [3:0]            dmem_byte_write,
    output logic [31:0]           dmem_data_in,
    input  logic [31:0]           tohost,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [31:0]           fail_code,
    output logic                  bad_cmd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR0 = 3'd1;
    localparam logic [2:0] S_ADDR1 = 3'd2;
    localparam logic [2:0] S_CNT0  = 3'd3;
    localparam logic [2:0] S_CNT1  = 3'd4;
    localparam logic [2:0] S_DATA  = 3'd5;
    localparam logic [2:0] S_WRITE = 3'd6;
    localparam logic [2:0] S_RUN   = 3'd7;

    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CYC_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CYC_LAST = CNT_WIDTH'(MAX_CYCLES - 1);

    logic [2:0]            state;
    logic                  tgt_imem;    // 1: frame targets ISPM, 0: DSPM
    logic [7:0]            addr_lo;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            cnt_lo;
    logic [15:0]           cnt;
    logic [1:0]            byte_idx;
    logic [31:0]           word;
    logic [CNT_WIDTH-1:0]  cycle_cnt;
    logic                  accept;
    logic                  is_write;
    logic                  tohost_fail;

    // Handshake and strobes are pure decodes of the registered state, so they are glitch-free and one cycle wide.
    always_comb begin
        in_ready        = (state != S_WRITE) && (state != S_RUN);
        accept          = in_valid && in_ready;
        busy            = (state != S_IDLE);
        is_write        = (state == S_WRITE);
        imem_enable     = is_write && tgt_imem;
        imem_write      = is_write && tgt_imem;
        imem_addr       = imem_enable ? addr : '0;
        imem_data_in    = imem_enable ? word : 32'h0;
        dmem_enable     = is_write && !tgt_imem;
        dmem_byte_write = {4{dmem_enable}};
        dmem_addr       = dmem_enable ? addr : '0;
        dmem_data_in    = dmem_enable ? word : 32'h0;
        // Values with bit 31 or 30 set are host I/O traffic, not an exit code.
        tohost_fail     = (tohost[31:30] == 2'b00) && (tohost[29:1] != 29'h0);
    end

    // Command parser, word assembler, writer and RUN monitor.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            tgt_imem   <= 1'b0;
            addr_lo    <= 8'h0;
            addr       <= '0;
            cnt_lo     <= 8'h0;
            cnt        <= 16'h0;
            byte_idx   <= 2'd0;
            word       <= 32'h0;
            cycle_cnt  <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_code  <= 32'h0;
            bad_cmd    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    case (in_data)
                        CMD_LOAD_I: begin
                            tgt_imem <= 1'b1;
                            state    <= S_ADDR0;
                        end
                        CMD_LOAD_D: begin
                            tgt_imem <= 1'b0;
                            state    <= S_ADDR0;
                        end
                        CMD_RUN: begin
                            done       <= 1'b0;
                            pass       <= 1'b0;
                            timeout    <= 1'b0;
                            fail_code  <= 32'h0;
                            cycle_cnt  <= '0;
                            core_reset <= 1'b0;
                            state      <= S_RUN;
                        end
                        default: bad_cmd <= 1'b1;
                    endcase
                end
                S_ADDR0: if (accept) begin
                    addr_lo <= in_data;
                    state   <= S_ADDR1;
                end
                S_ADDR1: if (accept) begin
                    // Address bits above the SPM size are dropped.
                    addr  <= ADDR_WIDTH'({in_data, addr_lo});
                    state <= S_CNT0;
                end
                S_CNT0: if (accept) begin
                    cnt_lo <= in_data;
                    state  <= S_CNT1;
                end
                S_CNT1: if (accept) begin
                    cnt      <= {in_data, cnt_lo};
                    byte_idx <= 2'd0;
                    state    <= ({in_data, cnt_lo} == 16'h0) ? S_IDLE : S_DATA;
                end
                S_DATA: if (accept) begin
                    word[{byte_idx, 3'b000} +: 8] <= in_data;
                    byte_idx <= byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state <= S_WRITE;
                end
                S_WRITE: begin
                    addr  <= addr + ADDR_ONE;
                    cnt   <= cnt - 16'd1;
                    state <= (cnt == 16'd1) ? S_IDLE : S_DATA;
                end
                S_RUN: begin
                    if (tohost_fail) begin
                        done       <= 1'b1;
                        fail_code  <= tohost;
                        core_reset <= 1'b1;
                        state      <= S_IDLE;
                    end else if (tohost == 32'h1) begin
                        done       <= 1'b1;
                        pass       <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= S_IDLE;
                    end else if (cycle_cnt == CYC_LAST) begin
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= S_IDLE;
                    end else begin
                        cycle_cnt <= cycle_cnt + CYC_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spm_host_loader.sv
`timescale 1ns/1ps
// Randomised bench for spm_host_loader with a queue-based write model and a status model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// A single monitor compares strobes and status every cycle; tasks pin latency and RUN length.
module tb_spm_host_loader;

    localparam int AW   = 12;
    localparam int MAXC = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          core_reset;
    logic [AW-1:0] imem_addr;
    logic          imem_enable;
    logic          imem_write;
    logic [31:0]   imem_data_in;
    logic [AW-1:0] dmem_addr;
    logic          dmem_enable;
    logic [3:0]    dmem_byte_write;
    logic [31:0]   dmem_data_in;
    logic [31:0]   tohost;
    logic          busy;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [31:0]   fail_code;
    logic          bad_cmd;

    spm_host_loader #(.ADDR_WIDTH(AW), .MAX_CYCLES(MAXC), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_reset(core_reset), .imem_addr(imem_addr), .imem_enable(imem_enable),
        .imem_write(imem_write), .imem_data_in(imem_data_in), .dmem_addr(dmem_addr),
        .dmem_enable(dmem_enable), .dmem_byte_write(dmem_byte_write), .dmem_data_in(dmem_data_in),
        .tohost(tohost), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_code(fail_code), .bad_cmd(bad_cmd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_i;
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    int          n_vec = 0;
    int          n_err = 0;
    wr_t         exp_q[$];
    logic [11:0] obs_q[$];
    logic [31:0] frame_words[$];
    logic [31:0] seq_q[$];
    bit          mon_en = 1'b0;
    bit          m_done, m_pass, m_timeout, m_bad;
    logic [31:0] m_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the expected-write queue; status always matches the model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (imem_enable || dmem_enable) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got imem_en=%b dmem_en=%b required none", imem_enable, dmem_enable);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_target", {imem_enable, dmem_enable}, e.is_i ? 2'b10 : 2'b01);
                    chk("wr_addr", e.is_i ? imem_addr : dmem_addr, e.addr);
                    chk("wr_data", e.is_i ? imem_data_in : dmem_data_in, e.data);
                    chk("wr_imem_write", imem_write, e.is_i);
                    chk("wr_byte_write", dmem_byte_write, e.is_i ? 4'h0 : 4'hF);
                    chk("wr_in_ready", in_ready, 0);
                    obs_q.push_back(e.is_i ? imem_addr : dmem_addr);
                end
            end else begin
                chk("quiet_strobes", {imem_write, dmem_byte_write}, 0);
            end
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("timeout", timeout, m_timeout);
            chk("fail_code", fail_code, m_fail);
            chk("bad_cmd", bad_cmd, m_bad);
        end
    end

    task automatic idle_gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a byte and hold it until the DUT takes it; returns 1ns after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL in_ready_wait: got in_ready=0 for %0d cycles required 1", t);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Send one LOAD frame built from frame_words; expected writes land at consecutive wrapped addresses.
    task automatic load_frame(input bit is_i, input logic [15:0] a);
        int          n;
        logic [31:0] w;
        n = frame_words.size();
        send_byte(is_i ? 8'h01 : 8'h02);
        idle_gap();
        send_byte(a[7:0]);
        send_byte(a[15:8]);
        idle_gap();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = frame_words[i];
            for (int b = 0; b < 4; b++) begin
                idle_gap();
                send_byte(w[8*b +: 8]);
            end
            exp_q.push_back('{is_i: is_i, addr: a[11:0] + 12'(i), data: w});
            @(negedge clk);
            chk("wr_latency", imem_enable | dmem_enable, 1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("frame_end_busy", busy, 0);
        chk("writes_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] seqv(input int k);
        if (k < seq_q.size()) return seq_q[k];
        return seq_q[seq_q.size() - 1];
    endfunction

    // Reference outcome of a RUN straight from the exit rules: first fail code, else pass, else timeout.
    function automatic void model_run(output int len, output bit p, output bit t, output logic [31:0] f);
        logic [31:0] v;
        len = MAXC;
        p = 1'b0;
        t = 1'b0;
        f = 32'h0;
        for (int k = 0; k < MAXC; k++) begin
            v = seqv(k);
            if (v[31:30] == 2'b00 && v > 32'd1) begin
                len = k + 1;
                f = v;
                return;
            end
            if (v == 32'd1) begin
                len = k + 1;
                p = 1'b1;
                return;
            end
        end
        t = 1'b1;
    endfunction

    // Issue RUN, feed tohost from seq_q one value per cycle and count core_reset-low cycles.
    task automatic run_prog(output int cycles);
        int          exp_len;
        bit          ep, et;
        logic [31:0] ef;
        model_run(exp_len, ep, et, ef);
        tohost = seqv(0);
        send_byte(8'h03);
        m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0; m_fail = 32'h0;
        cycles = 0;
        for (int g = 0; g < MAXC + 10; g++) begin
            @(negedge clk);
            if (core_reset) break;
            cycles++;
            chk("run_in_ready", in_ready, 0);
            chk("run_busy", busy, 1);
            @(posedge clk);
            #1;
            if (cycles == exp_len) begin
                m_done = 1'b1; m_pass = ep; m_timeout = et; m_fail = ef;
            end
            tohost = seqv(cycles);
        end
        chk("run_cycles", cycles, exp_len);
        chk("run_end_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0; m_fail = 32'h0; m_bad = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by 2ms required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [7:0]  b;
        logic [15:0] a;
        reset = 1'b0; in_valid = 1'b0; in_data = 8'h0; tohost = 32'h0;
        m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0; m_fail = 32'h0; m_bad = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_core_reset", core_reset, 1);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_enables", {imem_enable, imem_write, dmem_enable, dmem_byte_write}, 0);
        chk("reset_addr", {imem_addr, dmem_addr}, 0);
        chk("reset_data", imem_data_in | dmem_data_in, 0);
        chk("reset_status", {done, pass, timeout, bad_cmd}, 0);
        chk("reset_fail_code", fail_code, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // LOAD_I of two words at 0x010.
        obs_q.delete();
        frame_words = '{32'hDEADBEEF, 32'h00000013};
        load_frame(1'b1, 16'h0010);
        chk("loadi_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("loadi_addr0", obs_q[0], 12'h010);
            chk("loadi_addr1", obs_q[1], 12'h011);
        end

        // LOAD_D across the top of the address space.
        obs_q.delete();
        frame_words = '{32'($urandom), 32'($urandom)};
        load_frame(1'b0, 16'h0FFF);
        chk("loadd_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            chk("loadd_addr0", obs_q[0], 12'hFFF);
            chk("loadd_addr1", obs_q[1], 12'h000);
        end

        // Empty frame: no write.
        obs_q.delete();
        frame_words.delete();
        load_frame(1'b0, 16'h0000);
        chk("cnt0_no_write", obs_q.size(), 0);

        // Pass after five idle cycles.
        seq_q = '{0, 0, 0, 0, 0, 1};
        run_prog(cyc);
        chk("pass_len", cyc, 6);
        chk("pass_flags", {done, pass, timeout}, 3'b110);

        // Host I/O traffic ignored, then exit code 7.
        seq_q = '{32'h80000005, 32'h80000005, 32'h80000005, 32'h00000007};
        run_prog(cyc);
        chk("fail_len", cyc, 4);
        chk("fail_code_lit", fail_code, 32'h7);
        chk("fail_flags", {done, pass, timeout}, 3'b100);

        // Timeout, then a second RUN clears it.
        seq_q = '{0};
        run_prog(cyc);
        chk("timeout_len", cyc, MAXC);
        chk("timeout_flags", {done, pass, timeout}, 3'b101);
        seq_q = '{1};
        run_prog(cyc);
        chk("rerun_flags", {done, pass, timeout}, 3'b110);

        // Unknown command.
        send_byte(8'h55);
        m_bad = 1'b1;
        @(negedge clk);
        chk("badcmd_busy", busy, 0);
        @(posedge clk);
        #1;

        // Reset in the middle of a word, then a clean reload.
        send_byte(8'h01); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        pulse_reset();
        obs_q.delete();
        frame_words = '{32'h12345678};
        load_frame(1'b1, 16'h0020);
        chk("reload_count", obs_q.size(), 1);

        // Randomised mix of frames, runs and junk commands.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    frame_words.delete();
                    repeat ($urandom_range(0, 4)) frame_words.push_back(32'($urandom));
                    a = ($urandom_range(0, 1) == 1) ? 16'(16'h0FFC + $urandom_range(0, 3))
                                                    : 16'($urandom);
                    load_frame($urandom_range(0, 1) == 1, a);
                end
                2: begin
                    seq_q.delete();
                    repeat ($urandom_range(0, 8)) begin
                        if ($urandom_range(0, 1) == 1) seq_q.push_back(32'h0);
                        else seq_q.push_back({2'($urandom_range(1, 3)), 30'($urandom)});
                    end
                    case ($urandom_range(0, 2))
                        0: seq_q.push_back(32'h1);
                        1: seq_q.push_back({2'b00, 30'($urandom_range(2, 32'h3FFFFFFF))});
                        default: seq_q.push_back(32'h0);
                    endcase
                    run_prog(cyc);
                end
                default: begin
                    do b = 8'($urandom); while (b inside {8'h01, 8'h02, 8'h03});
                    send_byte(b);
                    m_bad = 1'b1;
                end
            endcase
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spm_host_loader.md
Name: spm_host_loader

Overview:
- Hardware host for the FlexPRET `Core` that replaces the simulation backdoor.
- Receives a byte stream of load and run commands, assembles 32-bit words and writes them through the core's external `io_imem_*` / `io_dmem_*` ports while holding the core in reset.
- On RUN it releases the core and monitors `io_host_to_host` for pass, fail or timeout.
- Sits between a serial/debug front-end and the core in the FPGA top level.

Parameters:
- ADDR_WIDTH, 12, word-address width of ISPM/DSPM.
- MAX_CYCLES, 10000, RUN cycles allowed before timeout.
- CNT_WIDTH, 32, width of the RUN cycle counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low; 0 resets block.
- in_valid  input  1  stream byte valid.
- in_ready  output  1  block accepts byte; transfer when in_valid&in_ready.
- in_data  input  8  stream byte.
- core_reset  output  1  active-high reset to Core.
- imem_addr  output  ADDR_WIDTH  to io_imem_addr.
- imem_enable  output  1  to io_imem_enable.
- imem_write  output  1  to io_imem_write.
- imem_data_in  output  32  to io_imem_data_in.
- dmem_addr  output  ADDR_WIDTH  to io_dmem_addr.
- dmem_enable  output  1  to io_dmem_enable.
- dmem_byte_write  output  4  to io_dmem_byte_write_3..0 (bit i -> _i).
- dmem_data_in  output  32  to io_dmem_data_in.
- tohost  input  32  from io_host_to_host.
- busy  output  1  state != IDLE.
- done  output  1  sticky: RUN finished.
- pass  output  1  sticky: tohost==1 seen.
- timeout  output  1  sticky: MAX_CYCLES reached.
- fail_code  output  32  tohost value at failure, else 0.
- bad_cmd  output  1  sticky: unknown command byte received.

Behaviour:
- Reset (reset==0 at clk edge): state IDLE, core_reset=1, all enables/writes 0, addr/data 0, status outputs 0, partial word discarded. Reset overrides any state including mid-word and RUN.

Command bytes, accepted in IDLE:
- 0x01 LOAD_I.
- 0x02 LOAD_D.
- 0x03 RUN.
- Any other value: byte consumed, bad_cmd=1, stay IDLE.

LOAD frame:
- Byte order: cmd, ADDR lo, ADDR hi, CNT lo, CNT hi, then 4*CNT data bytes. Each data word is little-endian (first byte = [7:0]).
- ADDR upper bits beyond ADDR_WIDTH are ignored.

States:
- IDLE -> ADDR0 -> ADDR1 -> CNT0 -> CNT1.
- CNT1: CNT==0 -> IDLE; else -> DATA.
- DATA: byte index 0..3; on 4th accepted byte -> WRITE.
- WRITE: exactly one cycle.
  - in_ready=0.
  - Target imem: imem_enable=1, imem_write=1, imem_addr=current address, imem_data_in=word.
  - Target dmem: dmem_enable=1, dmem_byte_write=4'b1111, dmem_addr=current address, dmem_data_in=word.
  - Then address += 1, wrapping mod 2^ADDR_WIDTH (0xFFF -> 0x000), and CNT -= 1.
  - CNT==0 -> IDLE; else -> DATA.
- Enables and byte_write are 0 in every cycle other than WRITE. Latency: write strobe is the cycle after the 4th byte of each word is accepted.
- in_ready=1 in IDLE, ADDR*, CNT*, DATA; 0 in WRITE and RUN.

RUN:
- Accepting RUN clears done, pass, timeout and fail_code, zeroes the cycle counter, and enters RUN.
- core_reset is registered: 0 in every RUN cycle, 1 in all other states.
- Each RUN cycle, tohost is sampled, evaluated in order:
  - tohost[31:30]==0 && tohost>1: fail. done=1, fail_code=tohost, -> IDLE.
  - else tohost==1: done=1, pass=1, -> IDLE.
  - else counter==MAX_CYCLES-1: done=1, timeout=1, -> IDLE.
  - else counter += 1.
- tohost with [31:30]!=0 is ignored (host I/O traffic).
- After leaving RUN, core_reset=1 on the next cycle; status is held until reset or the next RUN. Reloading after RUN is permitted.

Test Plan:
- LOAD_I: 01 10 00 02 00 EF BE AD DE 13 00 00 00 -> imem writes addr 0x010 data 0xDEADBEEF, then addr 0x011 data 0x00000013, one cycle each; in_ready=0 on those cycles; ends IDLE, busy=0.
- LOAD_D: 02 FF 0F 02 00 + two words -> dmem writes at 0xFFF then 0x000, dmem_byte_write=4'b1111; imem_enable stays 0; CNT=0 frame (02 00 00 00 00) -> no write, back to IDLE.
- RUN with tohost 0 for 5 cycles then 1 -> core_reset=0 for 6 cycles, pass=1, done=1, fail_code=0, core_reset=1 next cycle.
- RUN with tohost=0x80000005 for 3 cycles, then 0x00000007 -> first value ignored; fail_code=0x00000007, done=1, pass=0.
- MAX_CYCLES=20, RUN with tohost held 0 -> exactly 20 cycles with core_reset=0, then timeout=1, done=1; a second RUN clears the status.
- Byte 0x55 -> bad_cmd=1, no writes. Reset low after 2 data bytes of a LOAD_I word -> no imem write, state IDLE; the next frame loads correctly.
